// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - I2C target front-end for the TCPC register block
//
// Answers the bus master at a fixed 7-bit address. It keeps an 8-bit register
// pointer and turns written bytes into one-cycle register write strobes. Register
// reads are shifted back out on SDA, and the pointer auto-increments.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   reset      synchronous active-high reset
//   enb        block enable; low forces IDLE and releases the bus
//   scl        bus clock from the master (asynchronous)
//   sda_in     SDA as seen on the pin (asynchronous)
//   sda_oe     1 = pull SDA low (open-drain)
//   reg_addr   register address for the current strobe
//   reg_wdata  write data, valid with reg_wr
//   reg_wr     one-cycle write strobe
//   reg_rd     one-cycle read strobe
//   reg_rdata  read data, valid the cycle after reg_rd
//   busy       high while addressed, from START to STOP
module i2c_target #(
  parameter logic [6:0] DEV_ADDR = 7'h60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enb,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr,
  output logic       reg_rd,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_PTR,
    S_WDATA,
    S_RDATA,
    S_WAIT_STOP
  } state_t;

  state_t     state;
  state_t     state_next;
  logic       scl_s1, scl_s2, scl_d;
  logic       sda_s1, sda_s2, sda_d;
  logic [7:0] shreg;
  logic [7:0] ptr;
  logic [3:0] bit_cnt;
  logic       ack_phase;  // target-driven ACK slot, or master-ACK slot before next read byte
  logic       rd_load;    // reg_rdata is valid this cycle, load it into shreg

  logic scl_rise, scl_fall, start_det, stop_det, rx_state, byte_done, addr_match;

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_d  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_s1 <= scl;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= sda_in;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  assign scl_rise   = scl_s2 & ~scl_d;
  assign scl_fall   = ~scl_s2 & scl_d;
  assign start_det  = scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop_det   = scl_s2 & scl_d & ~sda_d & sda_s2;
  assign rx_state   = (state == S_ADDR) || (state == S_PTR) || (state == S_WDATA);
  // Eighth bit was sampled and its SCL low phase has begun: time to ACK.
  assign byte_done  = rx_state && scl_fall && !ack_phase && (bit_cnt == 4'd8);
  assign addr_match = (shreg[7:1] == DEV_ADDR);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    if (!enb) begin
      state_next = S_IDLE;
    end else if (start_det) begin
      state_next = S_ADDR;
    end else if (stop_det) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_ADDR: begin
          if (byte_done) begin
            if (!addr_match)   state_next = S_WAIT_STOP;
            else if (shreg[0]) state_next = S_RDATA;
            else               state_next = S_PTR;
          end
        end
        S_PTR: begin
          if (byte_done) state_next = S_WDATA;
        end
        S_RDATA: begin
          // Master NACK after a read byte ends the read.
          if (scl_rise && !ack_phase && (bit_cnt == 4'd9) && sda_s2) state_next = S_WAIT_STOP;
        end
        default: ;
      endcase
    end
  end

  // Output logic
  always_comb begin
    busy = 1'b0;
    case (state)
      S_ADDR, S_PTR, S_WDATA, S_RDATA: busy = 1'b1;
      default: ;
    endcase
  end

  // Datapath: shift register, bit counter, pointer, SDA drive and strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      sda_oe    <= 1'b0;
      reg_addr  <= 8'h00;
      reg_wdata <= 8'h00;
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      shreg     <= 8'h00;
      ptr       <= 8'h00;
      bit_cnt   <= 4'd0;
      ack_phase <= 1'b0;
      rd_load   <= 1'b0;
    end else begin
      reg_wr  <= 1'b0;
      reg_rd  <= 1'b0;
      rd_load <= reg_rd;
      if (!enb || start_det || stop_det) begin
        // Bus condition or disable: drop the partial byte and release at once.
        sda_oe    <= 1'b0;
        bit_cnt   <= 4'd0;
        ack_phase <= 1'b0;
        rd_load   <= 1'b0;
      end else begin
        if (rd_load) shreg <= reg_rdata;
        if (scl_fall && ack_phase) begin
          // End of an ACK slot: release, or present bit 7 of the next read byte.
          ack_phase <= 1'b0;
          bit_cnt   <= 4'd0;
          sda_oe    <= (state == S_RDATA) ? ~shreg[7] : 1'b0;
        end else begin
          case (state)
            S_ADDR, S_PTR, S_WDATA: begin
              if (scl_rise && !ack_phase && (bit_cnt < 4'd8)) begin
                shreg   <= {shreg[6:0], sda_s2};
                bit_cnt <= bit_cnt + 4'd1;
              end else if (byte_done) begin
                if (state == S_ADDR) begin
                  if (addr_match) begin
                    sda_oe    <= 1'b1;
                    ack_phase <= 1'b1;
                    if (shreg[0]) begin
                      reg_rd   <= 1'b1;
                      reg_addr <= ptr;
                    end
                  end
                end else begin
                  sda_oe    <= 1'b1;
                  ack_phase <= 1'b1;
                  if (state == S_PTR) begin
                    ptr <= shreg;
                  end else begin
                    reg_wr    <= 1'b1;
                    reg_addr  <= ptr;
                    reg_wdata <= shreg;
                    ptr       <= ptr + 8'd1;
                  end
                end
              end
            end
            S_RDATA: begin
              // bit_cnt counts SCL rises of the byte; 9 marks the master ACK slot.
              if (!ack_phase) begin
                if (scl_rise) begin
                  if (bit_cnt < 4'd8) begin
                    bit_cnt <= bit_cnt + 4'd1;
                  end else if ((bit_cnt == 4'd9) && !sda_s2) begin
                    reg_rd    <= 1'b1;
                    reg_addr  <= ptr + 8'd1;
                    ptr       <= ptr + 8'd1;
                    ack_phase <= 1'b1;
                  end
                end else if (scl_fall) begin
                  if (bit_cnt == 4'd8) begin
                    sda_oe  <= 1'b0;
                    bit_cnt <= 4'd9;
                  end else if (bit_cnt < 4'd8) begin
                    shreg  <= {shreg[6:0], 1'b0};
                    sda_oe <= ~shreg[6];
                  end
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
